// File: rtl/enemy_spawn_ctrl.sv
// Enemy slot scheduler: staggered initial launches, timed respawn after kills,
// saturating kill counter and a sticky game-over merged from per-slot deaths.
module enemy_spawn_ctrl #(
  parameter int N_ENEMY       = 4,
  parameter int SPAWN_GAP     = 2000000,
  parameter int RESPAWN_DELAY = 8000000,
  parameter int CNT_W         = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_start,
  input  logic [N_ENEMY-1:0]     bomb_kill,
  input  logic [N_ENEMY-1:0]     death_in,
  output logic [N_ENEMY-1:0]     enemy_rst,
  output logic [N_ENEMY-1:0]     enemy_start,
  output logic [10*N_ENEMY-1:0]  set_x_bus,
  output logic [10*N_ENEMY-1:0]  set_y_bus,
  output logic [N_ENEMY-1:0]     alive,
  output logic [7:0]             kill_count,
  output logic                   game_over,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            launch_idx_q, launch_idx_d;
  logic [CNT_W-1:0]      gap_q, gap_d;
  logic [N_ENEMY-1:0]    rst_q, rst_d;
  logic [N_ENEMY-1:0]    start_q, start_d;
  logic [N_ENEMY-1:0]    alive_q, alive_d;
  logic [N_ENEMY-1:0]    pend_q, pend_d;
  logic [N_ENEMY-1:0]    wait_q, wait_d;
  logic [1:0]            corner_q [N_ENEMY];
  logic [1:0]            corner_d [N_ENEMY];
  logic [CNT_W-1:0]      resp_q [N_ENEMY];
  logic [CNT_W-1:0]      resp_d [N_ENEMY];
  logic [7:0]            kill_q, kill_d;
  logic                  over_q, over_d;
  logic [10*N_ENEMY-1:0] setx_q, setx_d;
  logic [10*N_ENEMY-1:0] sety_q, sety_d;
  logic [N_ENEMY-1:0]    kill_v;
  logic [8:0]            kill_sum;

  function automatic logic [9:0] corner_x(input logic [1:0] c);
    return (c == 2'd0 || c == 2'd3) ? 10'd143 : 10'd768;
  endfunction

  function automatic logic [9:0] corner_y(input logic [1:0] c);
    return c[1] ? 10'd500 : 10'd34;
  endfunction

  always_comb begin
    state_d      = state_q;
    launch_idx_d = launch_idx_q;
    gap_d        = gap_q;
    rst_d        = rst_q;
    start_d      = '0;
    alive_d      = alive_q;
    pend_d       = pend_q;
    wait_d       = wait_q;
    corner_d     = corner_q;
    resp_d       = resp_q;
    kill_d       = kill_q;
    over_d       = over_q;
    kill_v       = '0;
    kill_sum     = '0;
    setx_d       = '0;
    sety_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (game_start) begin
          state_d      = S_STAGGER;
          launch_idx_d = '0;
          gap_d        = '0;
        end
      end
      S_STAGGER, S_RUN: begin
        if (|(death_in & alive_q)) begin
          // Death freezes everything; a pending start pulse is dropped.
          state_d = S_OVER;
          over_d  = 1'b1;
          pend_d  = '0;
        end else begin
          start_d = pend_q;
          alive_d = alive_q | pend_q;
          pend_d  = '0;
          // A slot in its start-pulse cycle cannot be killed yet.
          kill_v  = bomb_kill & alive_q & ~start_q & ~death_in;
          for (int i = 0; i < N_ENEMY; i++) begin
            if (kill_v[i]) begin
              alive_d[i]  = 1'b0;
              rst_d[i]    = 1'b1;
              wait_d[i]   = 1'b1;
              corner_d[i] = corner_q[i] + 2'd1;
              resp_d[i]   = CNT_W'(RESPAWN_DELAY - 1);
            end else if (wait_q[i]) begin
              if (resp_q[i] == '0) begin
                rst_d[i]  = 1'b0;
                pend_d[i] = 1'b1;
                wait_d[i] = 1'b0;
              end else begin
                resp_d[i] = resp_q[i] - 1'b1;
              end
            end
          end
          if (state_q == S_STAGGER) begin
            if (gap_q == '0) begin
              gap_d = CNT_W'(SPAWN_GAP - 1);
              for (int i = 0; i < N_ENEMY; i++) begin
                if (launch_idx_q == 2'(i)) begin
                  rst_d[i]  = 1'b0;
                  pend_d[i] = 1'b1;
                end
              end
              if (launch_idx_q == 2'(N_ENEMY - 1)) state_d = S_RUN;
              else launch_idx_d = launch_idx_q + 2'd1;
            end else begin
              gap_d = gap_q - 1'b1;
            end
          end
          kill_sum = {1'b0, kill_q};
          for (int i = 0; i < N_ENEMY; i++) kill_sum = kill_sum + 9'(kill_v[i]);
          kill_d = (kill_sum > 9'd255) ? 8'hFF : kill_sum[7:0];
        end
      end
      default: ;
    endcase

    for (int i = 0; i < N_ENEMY; i++) begin
      setx_d[10*i +: 10] = corner_x(corner_d[i]);
      sety_d[10*i +: 10] = corner_y(corner_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      launch_idx_q <= '0;
      gap_q        <= '0;
      rst_q        <= '1;
      start_q      <= '0;
      alive_q      <= '0;
      pend_q       <= '0;
      wait_q       <= '0;
      kill_q       <= '0;
      over_q       <= 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
        corner_q[i]          <= 2'(i);
        resp_q[i]            <= '0;
        setx_q[10*i +: 10]   <= corner_x(2'(i));
        sety_q[10*i +: 10]   <= corner_y(2'(i));
      end
    end else begin
      state_q      <= state_d;
      launch_idx_q <= launch_idx_d;
      gap_q        <= gap_d;
      rst_q        <= rst_d;
      start_q      <= start_d;
      alive_q      <= alive_d;
      pend_q       <= pend_d;
      wait_q       <= wait_d;
      kill_q       <= kill_d;
      over_q       <= over_d;
      corner_q     <= corner_d;
      resp_q       <= resp_d;
      setx_q       <= setx_d;
      sety_q       <= sety_d;
    end
  end

  assign enemy_rst   = rst_q;
  assign enemy_start = start_q;
  assign alive       = alive_q;
  assign kill_count  = kill_q;
  assign game_over   = over_q;
  assign set_x_bus   = setx_q;
  assign set_y_bus   = sety_q;
  assign dbg_state   = state_q;

endmodule
